// File: rtl/spike_monitor.sv
`default_nettype none
// ============================================================================
// Module      : spike_monitor
// Description : Watches the single-bit spike stream from a LIF neuron.
//               Detects rising edges, counts them over a programmable
//               window (saturating), and measures the inter-spike interval
//               in cycles (saturating at 255). Registered outputs with
//               one-cycle valid pulses.
// Ports       : clk        - block clock
//               reset_n    - synchronous active-low reset
//               spk        - spike level, already registered upstream
//               win_len    - window length minus one, in cycles
//               rate       - edge count of the last completed window
//               rate_valid - one-cycle pulse when rate updates
//               isi        - cycles between the last two spike edges
//               isi_valid  - one-cycle pulse when isi updates
// Revision    : 1.0 - initial release
// ============================================================================
module spike_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spk,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [7:0]       isi,
  output logic             isi_valid
);

  localparam logic [0:0]       C_ST_WAIT_FIRST = 1'b0;
  localparam logic [0:0]       C_ST_TRACK      = 1'b1;
  localparam logic [CNT_W-1:0] C_CNT_MAX       = {CNT_W{1'b1}};
  localparam logic [7:0]       C_ICNT_MAX      = 8'hFF;

  logic             spk_d_q,      spk_d_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIN_W-1:0] wcnt_q,       wcnt_d;
  logic [WIN_W-1:0] win_len_q,    win_len_d;
  logic [CNT_W-1:0] rate_q,       rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [0:0]       state_q,      state_d;
  logic [7:0]       icnt_q,       icnt_d;
  logic [7:0]       isi_q,        isi_d;
  logic             isi_valid_q,  isi_valid_d;

  logic             w_edge;
  logic             w_close;
  logic [CNT_W-1:0] w_cnt_sat;

  // spk is already registered upstream, so the edge is used combinationally.
  assign w_edge    = spk & ~spk_d_q;
  assign w_close   = (wcnt_q == win_len_q);
  // Count including this cycle's edge, so a closing-cycle edge lands in the
  // window that is closing.
  assign w_cnt_sat = (cnt_q == C_CNT_MAX) ? C_CNT_MAX
                                          : cnt_q + {{(CNT_W-1){1'b0}}, w_edge};

  // Window counter and rate path
  always_comb begin
    spk_d_d      = spk;
    win_len_d    = win_len_q;
    cnt_d        = w_cnt_sat;
    wcnt_d       = wcnt_q + {{(WIN_W-1){1'b0}}, 1'b1};
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    if (w_close) begin
      rate_d       = w_cnt_sat;
      rate_valid_d = 1'b1;
      cnt_d        = '0;
      wcnt_d       = '0;
      // A new length only takes effect at a window boundary.
      win_len_d    = win_len;
    end
  end

  // Inter-spike interval tracker
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    isi_d       = isi_q;
    isi_valid_d = isi_valid_q;
    case (state_q)
      C_ST_WAIT_FIRST: begin
        // First edge only starts the interval; there is nothing to report.
        if (w_edge) begin
          state_d = C_ST_TRACK;
          icnt_d  = 8'd1;
        end
      end
      C_ST_TRACK: begin
        icnt_d      = (icnt_q == C_ICNT_MAX) ? C_ICNT_MAX : icnt_q + 8'd1;
        isi_valid_d = 1'b0;
        if (w_edge) begin
          isi_d       = icnt_q;
          isi_valid_d = 1'b1;
          icnt_d      = 8'd1;
        end
      end
      default: state_d = C_ST_WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spk_d_q      <= 1'b0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      win_len_q    <= win_len;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      state_q      <= C_ST_WAIT_FIRST;
      icnt_q       <= 8'd0;
      isi_q        <= 8'd0;
      isi_valid_q  <= 1'b0;
    end else begin
      spk_d_q      <= spk_d_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      win_len_q    <= win_len_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      state_q      <= state_d;
      icnt_q       <= icnt_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign isi        = isi_q;
  assign isi_valid  = isi_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_monitor
// Description : Directed, self-checking bench for spike_monitor. Expected
//               rate/isi results are queued with the cycle they are due and
//               compared when the design raises its valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_monitor;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       spk;
  logic [7:0] win_len;
  logic [7:0] rate;
  logic       rate_valid;
  logic [7:0] isi;
  logic       isi_valid;

  logic       spk_s;
  logic [7:0] win_len_s;
  logic [2:0] rate_s;
  logic       rate_valid_s;
  logic [7:0] isi_s;
  logic       isi_valid_s;

  exp_t rq[$];
  exp_t iq[$];
  int   cyc;
  int   n_assert;
  int   n_fail;

  spike_monitor #(.CNT_W(8), .WIN_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spk        (spk),
    .win_len    (win_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .isi        (isi),
    .isi_valid  (isi_valid)
  );

  spike_monitor #(.CNT_W(3), .WIN_W(8)) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .spk        (spk_s),
    .win_len    (win_len_s),
    .rate       (rate_s),
    .rate_valid (rate_valid_s),
    .isi        (isi_s),
    .isi_valid  (isi_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_rate(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = v[7:0];
    rq.push_back(e);
  endtask

  task automatic push_isi(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = v[7:0];
    iq.push_back(e);
  endtask

  task automatic check_rate();
    exp_t e;
    logic due;
    due = (rq.size() > 0) && (rq[0].cyc == cyc);
    if (rate_valid === 1'b1 || due) begin
      n_assert++;
      assert (rate_valid === 1'b1 && due) else begin
        n_fail++;
        $error("FAIL rate_valid_timing cyc=%0d observed=%b expected=%b", cyc, rate_valid, due);
      end
      if (due) begin
        e = rq.pop_front();
        if (rate_valid === 1'b1) begin
          n_assert++;
          assert (rate === e.val) else begin
            n_fail++;
            $error("FAIL rate_value cyc=%0d observed=%0d expected=%0d", cyc, rate, e.val);
          end
        end
      end
    end
  endtask

  task automatic check_isi();
    exp_t e;
    logic due;
    due = (iq.size() > 0) && (iq[0].cyc == cyc);
    if (isi_valid === 1'b1 || due) begin
      n_assert++;
      assert (isi_valid === 1'b1 && due) else begin
        n_fail++;
        $error("FAIL isi_valid_timing cyc=%0d observed=%b expected=%b", cyc, isi_valid, due);
      end
      if (due) begin
        e = iq.pop_front();
        if (isi_valid === 1'b1) begin
          n_assert++;
          assert (isi === e.val) else begin
            n_fail++;
            $error("FAIL isi_value cyc=%0d observed=%0d expected=%0d", cyc, isi, e.val);
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, check outputs just after.
  task automatic tick(input logic s, input logic ss);
    spk   = s;
    spk_s = ss;
    @(posedge clk);
    #1;
    cyc++;
    check_rate();
    check_isi();
  endtask

  task automatic do_reset(input int n, input logic s, input logic [7:0] wl);
    win_len = wl;
    reset_n = 1'b0;
    repeat (n) tick(s, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    n_assert++;
    assert (rate === 8'd0) else begin
      n_fail++;
      $error("FAIL %s_rate observed=%0d expected=0", tag, rate);
    end
    n_assert++;
    assert (rate_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_rate_valid observed=%b expected=0", tag, rate_valid);
    end
    n_assert++;
    assert (isi === 8'd0) else begin
      n_fail++;
      $error("FAIL %s_isi observed=%0d expected=0", tag, isi);
    end
    n_assert++;
    assert (isi_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_isi_valid observed=%b expected=0", tag, isi_valid);
    end
  endtask

  initial begin
    int s;
    logic [4:0] pat;
    logic [4:0] edg;

    cyc       = 0;
    n_assert  = 0;
    n_fail    = 0;
    spk       = 1'b0;
    spk_s     = 1'b0;
    reset_n   = 1'b0;
    win_len   = 8'd19;
    win_len_s = 8'd31;

    // Reset with spk high, then a 10-cycle level hold (one edge) and a
    // second edge 14 cycles after the first.
    do_reset(3, 1'b1, 8'd19);
    check_zero("reset");
    s = cyc;
    push_isi(s + 15, 14);
    push_rate(s + 20, 2);
    for (int n = 1; n <= 20; n++) tick((n <= 10) || (n == 15), 1'b0);

    // Periodic spikes every 5 cycles starting 2 after reset; the 3-bit
    // instance sees a toggling input giving 16 edges per 32-cycle window.
    do_reset(2, 1'b0, 8'd19);
    s = cyc;
    for (int w = 1; w <= 3; w++) push_rate(s + 20 * w, 4);
    for (int j = 0; j <= 10; j++) push_isi(s + 8 + 5 * j, 5);
    for (int n = 1; n <= 60; n++) begin
      tick((n >= 3) && ((n - 3) % 5 == 0), (n <= 32) && (n % 2 == 1));
      if (n == 32) begin
        n_assert++;
        assert (rate_valid_s === 1'b1) else begin
          n_fail++;
          $error("FAIL sat_rate_valid observed=%b expected=1", rate_valid_s);
        end
        n_assert++;
        assert (rate_s === 3'd7) else begin
          n_fail++;
          $error("FAIL sat_rate observed=%0d expected=7", rate_s);
        end
      end
    end

    // ISI saturation: edges 300 cycles apart, then 3 apart.
    do_reset(2, 1'b0, 8'd255);
    s = cyc;
    push_rate(s + 256, 1);
    push_isi(s + 302, 255);
    push_isi(s + 305, 3);
    for (int n = 1; n <= 310; n++) tick((n == 2) || (n == 302) || (n == 305), 1'b0);

    // Window length change mid-window plus edges on closing cycles.
    do_reset(2, 1'b0, 8'd9);
    s = cyc;
    push_rate(s + 10, 2);
    push_rate(s + 15, 1);
    push_rate(s + 20, 2);
    push_rate(s + 25, 1);
    push_isi(s + 10, 7);
    push_isi(s + 15, 5);
    push_isi(s + 17, 2);
    push_isi(s + 19, 2);
    push_isi(s + 25, 6);
    for (int n = 1; n <= 25; n++) begin
      if (n == 5) win_len = 8'd4;
      tick((n == 3) || (n == 10) || (n == 15) || (n == 17) || (n == 19) || (n == 25), 1'b0);
    end

    // Reset mid-window: partial count discarded, next window post-reset only.
    do_reset(2, 1'b0, 8'd19);
    s = cyc;
    push_isi(s + 4, 2);
    push_isi(s + 6, 2);
    for (int n = 1; n <= 8; n++) tick((n == 2) || (n == 4) || (n == 6), 1'b0);
    do_reset(2, 1'b0, 8'd19);
    check_zero("mid_reset");
    s = cyc;
    push_rate(s + 20, 1);
    for (int n = 1; n <= 20; n++) tick(n == 5, 1'b0);

    // One-cycle window: rate tracks the edge of each cycle.
    do_reset(2, 1'b0, 8'd0);
    s   = cyc;
    pat = 5'b01101;
    edg = 5'b00101;
    for (int n = 1; n <= 5; n++) push_rate(s + n, int'(edg[n-1]));
    push_isi(s + 3, 2);
    for (int n = 1; n <= 5; n++) tick(pat[n-1], 1'b0);

    n_assert++;
    assert (rq.size() == 0 && iq.size() == 0) else begin
      n_fail++;
      $error("FAIL pending_expectations observed=%0d/%0d expected=0/0", rq.size(), iq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_monitor.md
# spike_monitor

Downstream consumer of the LIF neuron's spike output: detects spike rising edges, counts them over a programmable window, and measures the inter-spike interval (ISI). It turns the single-bit `spk` stream into registered rate and ISI values for readout on the tile's output pins or for a later host interface. It is fully synchronous and adds no feedback to the neuron.

## Interface

- `CNT_W`, default 8: width of the spike counter and the `rate` output.
- `WIN_W`, default 8: width of the `win_len` window-length input.
- `clk`, in, 1: single clock for the block.
- `reset_n`, in, 1: synchronous, active-low reset.
- `spk`, in, 1: spike from the LIF neuron, registered upstream.
- `win_len`, in, WIN_W: window length minus 1, in cycles. `0` gives a 1-cycle window.
- `rate`, out, CNT_W: spike-edge count of the last completed window, saturating.
- `rate_valid`, out, 1: one-cycle pulse when `rate` updates.
- `isi`, out, 8: cycles between the last two spike edges, saturating at 255.
- `isi_valid`, out, 1: one-cycle pulse when `isi` updates.

## Operation

- **Edge detect:** `spk_d` holds `spk` from the previous cycle. `edge = spk & ~spk_d` (combinational, because `spk` is already registered). A `spk` level held high counts as one edge.
- **Window:**
  - `wcnt` counts `0..win_len_q`. `win_len_q` is latched from `win_len` at reset release and at each window close.
  - A change on `win_len` mid-window takes effect from the next window.
  - Each cycle, `cnt` increments on `edge`, saturating at 2^CNT_W−1.
  - Window close (`wcnt == win_len_q`):
    - `rate <= sat(cnt + edge)`, so an edge on the closing cycle belongs to the closing window.
    - `rate_valid <= 1`.
    - `cnt <= 0`, `wcnt <= 0`.
  - Otherwise `wcnt` increments and `rate_valid <= 0`.
- **ISI FSM, two states:**
  - `WAIT_FIRST` (reset state): on `edge`, go to `TRACK` and set `icnt <= 1`. `isi` and `isi_valid` are unchanged.
  - `TRACK`:
    - Every cycle, `icnt <= icnt + 1`, saturating at 255.
    - On `edge`: `isi <= icnt`, `isi_valid <= 1`, `icnt <= 1`.
    - Otherwise `isi_valid <= 0`.
  - Result: edges at cycles t0 and t1 give `isi = min(t1 − t0, 255)`.
- **Arithmetic:** all counters are unsigned and saturate. Nothing wraps.

## Timing

- **Reset** (`reset_n` low at a rising `clk` edge): all of the following are 0.
  - Outputs: `rate`, `rate_valid`, `isi`, `isi_valid`.
  - Internal: `spk_d`, `cnt`, `wcnt`, `icnt`.
  - FSM goes to `WAIT_FIRST`; `win_len_q` loads `win_len`.
  - Reset mid-window discards the partial count, and no `rate_valid` is issued for it.
- **First window:** with reset released before edge k, the first window covers cycles k..k+win_len_q. `rate_valid` is high in cycle k+win_len_q+1.
- **Latency:**
  - `isi`/`isi_valid` are visible 1 cycle after the edge cycle.
  - `rate`/`rate_valid` are visible 1 cycle after the closing cycle.
- **`win_len = 0`:** the window closes every cycle. `rate` equals `edge` of the previous cycle and `rate_valid` stays high continuously.
- **Simultaneous events:** an edge on a window-close cycle is counted in the closing window and also updates the ISI the same cycle. The two paths are independent.
- **Pulses:** `rate_valid` and `isi_valid` are single-cycle with no handshake. A consumer must sample them on the pulse.

## Test plan

- **Reset:** hold `reset_n` low for 3 cycles with `spk = 1` → all outputs 0, and no `isi_valid` follows the first post-reset edge.
- **Periodic spiking:** `win_len = 19`, one-cycle spikes every 5 cycles starting 2 cycles after reset:
  - `rate = 4` with `rate_valid` every 20 cycles.
  - `isi = 5` with `isi_valid` one cycle after every spike except the first.
- **Count saturation:** `CNT_W = 3`, `win_len = 31`, `spk` toggling every cycle (16 edges per window) → `rate = 7`.
- **ISI saturation and level hold:**
  - Spikes 300 cycles apart → `isi = 255`.
  - `spk` held high for 10 cycles → counted as one edge, with no ISI update until the next rising edge.
- **Window change and boundary edge:**
  - Change `win_len` from 9 to 4 at the mid-point of a window → the current window still closes after 10 cycles, and the following windows last 5 cycles.
  - An edge on the closing cycle is included in that window's `rate`.
- **Reset mid-window:** 3 edges, then reset before the window closes → no `rate_valid` for that window, and the next window reports only post-reset edges.
